// File: rtl/regfile_pkg.sv
// Shared widths and the write-request record used between the arbiter and its
// secondary-result FIFO.
package regfile_pkg;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] val;
    } rf_wr_t;
endpackage

// File: rtl/rf_wr_fifo.sv
// Synchronous FIFO of register-file write requests; head is visible on dout
// combinationally while not empty.
module rf_wr_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  rf_wr_t din,
    input  logic   pop,
    output rf_wr_t dout,
    output logic   full,
    output logic   empty
);
    localparam int AW = $clog2(DEPTH);

    rf_wr_t        mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign dout  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + 1'b1;
            if (pop && !empty)
                rptr <= rptr + 1'b1;
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file's single write port between writeback (priority)
// and buffered multi-cycle results; tracks reserved destinations for hazard stalls.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_val,
    input  logic              mc_issue,
    input  logic [ADDR_W-1:0] mc_issue_dest,
    input  logic              mc_valid,
    input  logic [ADDR_W-1:0] mc_dest,
    input  logic [DATA_W-1:0] mc_val,
    output logic              mc_ready,
    input  logic [ADDR_W-1:0] hz_src1,
    input  logic [ADDR_W-1:0] hz_src2,
    input  logic [ADDR_W-1:0] hz_dest,
    output logic              hz_stall,
    output logic              pipe_hold,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_dest,
    output logic [DATA_W-1:0] rf_wval,
    output logic              sb_err
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    rf_wr_t              head;
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] set_mask;
    logic                issue_nz;
    logic                issue_conflict;
    logic                starve_inc;
    logic [SW-1:0]       starve_cnt;

    assign mc_ready = !full && !rst;
    assign push     = mc_valid && mc_ready;
    assign pop      = !wb_en && !empty;

    rf_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({mc_dest, mc_val}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // Clear is applied before set so a same-cycle retire and re-issue stays reserved.
    assign issue_nz       = mc_issue && (mc_issue_dest != '0);
    assign clr_mask       = pop      ? (NUM_REGS'(1) << head.dest)     : '0;
    assign set_mask       = issue_nz ? (NUM_REGS'(1) << mc_issue_dest) : '0;
    assign issue_conflict = issue_nz && pending[mc_issue_dest]
                            && !(pop && (head.dest == mc_issue_dest));

    assign hz_stall = ((hz_src1 != '0) && pending[hz_src1])
                   || ((hz_src2 != '0) && pending[hz_src2])
                   || ((hz_dest != '0) && pending[hz_dest]);

    assign starve_inc = !empty && wb_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we      <= 1'b0;
            rf_dest    <= '0;
            rf_wval    <= '0;
            pipe_hold  <= 1'b0;
            sb_err     <= 1'b0;
            pending    <= '0;
            starve_cnt <= '0;
        end else begin
            if (wb_en) begin
                rf_we   <= (wb_dest != '0);
                rf_dest <= wb_dest;
                rf_wval <= wb_val;
            end else if (!empty) begin
                rf_we   <= (head.dest != '0);
                rf_dest <= head.dest;
                rf_wval <= head.val;
            end else begin
                rf_we   <= 1'b0;
            end

            pending <= (pending & ~clr_mask) | set_mask;

            if (issue_conflict || (pipe_hold && wb_en))
                sb_err <= 1'b1;

            pipe_hold <= 1'b0;
            if (!starve_inc) begin
                starve_cnt <= '0;
            end else if (starve_cnt == SW'(STARVE_MAX - 1)) begin
                starve_cnt <= '0;
                pipe_hold  <= 1'b1;
            end else begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: a queue-based model predicts every register-file write and
// flag; a monitor retires predicted writes whenever the DUT asserts rf_we.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    localparam int DEPTH = 4;
    localparam int SMAX  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0] wb_val;
    logic              mc_issue;
    logic [ADDR_W-1:0] mc_issue_dest;
    logic              mc_valid;
    logic [ADDR_W-1:0] mc_dest;
    logic [DATA_W-1:0] mc_val;
    logic              mc_ready;
    logic [ADDR_W-1:0] hz_src1;
    logic [ADDR_W-1:0] hz_src2;
    logic [ADDR_W-1:0] hz_dest;
    logic              hz_stall;
    logic              pipe_hold;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_dest;
    logic [DATA_W-1:0] rf_wval;
    logic              sb_err;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_val(wb_val),
        .mc_issue(mc_issue), .mc_issue_dest(mc_issue_dest),
        .mc_valid(mc_valid), .mc_dest(mc_dest), .mc_val(mc_val), .mc_ready(mc_ready),
        .hz_src1(hz_src1), .hz_src2(hz_src2), .hz_dest(hz_dest), .hz_stall(hz_stall),
        .pipe_hold(pipe_hold), .rf_we(rf_we), .rf_dest(rf_dest), .rf_wval(rf_wval),
        .sb_err(sb_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    rf_wr_t              exp_q[$];
    rf_wr_t              m_fifo[$];
    logic [NUM_REGS-1:0] m_pend;
    int                  m_cnt;
    logic                m_hold;
    logic                m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_fifo.delete();
        m_pend = '0;
        m_cnt  = 0;
        m_hold = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic idle();
        wb_en = 0; wb_dest = 0; wb_val = 0;
        mc_issue = 0; mc_issue_dest = 0;
        mc_valid = 0; mc_dest = 0; mc_val = 0;
        hz_src1 = 0; hz_src2 = 0; hz_dest = 0;
    endtask

    // Called at a negedge with inputs set: checks current flags, predicts the
    // effect of the coming posedge, then advances to the next negedge.
    task automatic tick();
        int     sz;
        rf_wr_t h;
        #1;
        sz = m_fifo.size();
        chk("mc_ready", mc_ready, sz < DEPTH);
        chk("hz_stall", hz_stall, m_pend[hz_src1] | m_pend[hz_src2] | m_pend[hz_dest]);
        chk("pipe_hold", pipe_hold, m_hold);
        chk("sb_err", sb_err, m_err);
        if (wb_en) begin
            if (wb_dest != 0) exp_q.push_back(rf_wr_t'{dest: wb_dest, val: wb_val});
        end else if (sz > 0) begin
            h = m_fifo.pop_front();
            if (h.dest != 0) exp_q.push_back(h);
            m_pend[h.dest] = 1'b0;
        end
        if (m_hold && wb_en) m_err = 1'b1;
        if (mc_issue && mc_issue_dest != 0) begin
            if (m_pend[mc_issue_dest]) m_err = 1'b1;
            m_pend[mc_issue_dest] = 1'b1;
        end
        if (mc_valid && sz < DEPTH) m_fifo.push_back(rf_wr_t'{dest: mc_dest, val: mc_val});
        if (sz > 0 && wb_en) begin
            m_cnt++;
            m_hold = (m_cnt == SMAX);
            if (m_hold) m_cnt = 0;
        end else begin
            m_cnt  = 0;
            m_hold = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin : monitor
        rf_wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && rf_we) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_write: got dest %0d val %0h expected no write (t=%0t)",
                             rf_dest, rf_wval, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("rf_dest", rf_dest, e.dest);
                    chk("rf_wval", rf_wval, e.val);
                end
            end
        end
    end

    initial begin : stim
        int hold_at;
        rst = 1'b1;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_dest", rf_dest, 0);
        chk("rst_rf_wval", rf_wval, 0);
        chk("rst_pipe_hold", pipe_hold, 0);
        chk("rst_sb_err", sb_err, 0);
        chk("rst_mc_ready", mc_ready, 0);
        rst = 1'b0;

        // Primary write, one-edge latency.
        wb_en = 1; wb_dest = 3; wb_val = 32'hA5;
        tick();
        idle();
        chk("wb_rf_we", rf_we, 1);
        chk("wb_rf_dest", rf_dest, 3);
        tick();

        // Reservation, stall, retirement through the FIFO.
        mc_issue = 1; mc_issue_dest = 7;
        tick();
        idle();
        hz_src1 = 7;
        #1 chk("hz_stall_7", hz_stall, 1);
        mc_valid = 1; mc_dest = 7; mc_val = 32'h55;
        tick();
        mc_valid = 0;
        tick();
        chk("mc_rf_we", rf_we, 1);
        chk("mc_rf_dest", rf_dest, 7);
        tick();

        // Starvation: one queued entry behind continuous writeback.
        idle();
        wb_en = 1; wb_dest = 5; wb_val = 32'h1111;
        mc_valid = 1; mc_dest = 12; mc_val = 32'hBEEF;
        tick();
        mc_valid = 0;
        hold_at = -1;
        for (int i = 0; i < 12; i++) begin
            if (pipe_hold) begin hold_at = i; break; end
            wb_val = $urandom;
            tick();
        end
        chk("starve_hold_after", hold_at, SMAX);
        wb_en = 0;
        tick();
        chk("starve_pop_dest", rf_dest, 12);
        chk("starve_no_err", sb_err, 0);
        tick();

        // Fill the FIFO behind writeback, refuse the fifth, drain in order.
        idle();
        wb_en = 1;
        for (int i = 0; i < 5; i++) begin
            wb_dest = 1; wb_val = $urandom;
            mc_valid = 1; mc_dest = ADDR_W'(i + 1); mc_val = $urandom;
            if (i == 4) chk("full_mc_ready", mc_ready, 0);
            tick();
        end
        idle();
        repeat (6) tick();

        // Double reservation sets sticky error; dest 0 result is popped silently.
        mc_issue = 1; mc_issue_dest = 4;
        tick();
        tick();
        mc_issue = 0;
        chk("double_issue_err", sb_err, 1);
        mc_valid = 1; mc_dest = 0; mc_val = 32'hDEAD;
        tick();
        mc_valid = 0;
        tick();
        chk("dest0_no_we", rf_we, 0);
        chk("sticky_err", sb_err, 1);

        // Clear reservation on 4, then reset with work in flight.
        mc_valid = 1; mc_dest = 4; mc_val = 32'h44;
        tick();
        idle();
        tick();
        mc_issue = 1; mc_issue_dest = 9;
        wb_en = 1; wb_dest = 2; wb_val = 32'h22;
        tick();
        mc_issue = 0;
        for (int i = 0; i < 3; i++) begin
            mc_valid = 1; mc_dest = ADDR_W'(20 + i); mc_val = $urandom;
            tick();
        end
        rst = 1'b1;
        #1;
        chk("midrst_rf_we", rf_we, 0);
        chk("midrst_mc_ready", mc_ready, 0);
        chk("midrst_hz_stall", hz_stall, 0);
        model_reset();
        idle();
        @(negedge clk);
        rst = 1'b0;
        hz_src1 = 9;
        repeat (6) tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            wb_en    = pipe_hold ? ($urandom_range(15) == 0) : $urandom_range(1);
            wb_dest  = ADDR_W'($urandom);
            wb_val   = $urandom;
            mc_issue = ($urandom_range(3) == 0);
            mc_issue_dest = ADDR_W'($urandom);
            mc_valid = $urandom_range(1);
            mc_dest  = ADDR_W'($urandom);
            mc_val   = $urandom;
            hz_src1  = ADDR_W'($urandom);
            hz_src2  = ADDR_W'($urandom);
            hz_dest  = ADDR_W'($urandom);
            tick();
        end
        idle();
        repeat (8) tick();
        chk("exp_q_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
